// File: rtl/uart_rx_frame_ctrl_pkg.sv
// rtl/uart_rx_frame_ctrl_pkg.sv - shared UART framing constants and FSM state encodings
package uart_rx_frame_ctrl_pkg;

    localparam int         TICKS_PER_BIT = 16;
    localparam logic [7:0] DEFAULT_SOF   = 8'hA5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    function automatic int tmo_limit(input int bit_times);
        return bit_times * TICKS_PER_BIT;
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// rtl/uart_timeout_cnt.sv - s_tick counter with clear and terminal-count strobe
module uart_timeout_cnt #(
    parameter int LIMIT = 320
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic terminal
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;
    logic         at_end;

    assign at_end = (cnt == W'(LIMIT - 1));

    // clear masks the strobe so a same-cycle restart never reports expiry
    assign terminal = tick & at_end & ~clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - SOF hunt, payload assembly and valid/ready hand-off for UART bytes
// Optional trailing XOR checksum byte enabled by UART_FRAME_CHKSUM_EN.
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int              DBIT         = 8,
    parameter int              NBYTES       = 3,
    parameter logic [DBIT-1:0] SOF          = DBIT'(DEFAULT_SOF),
    parameter int              TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_tick,
    input  logic                   rx_done_tick,
    input  logic [DBIT-1:0]        rx_data,
    output logic [NBYTES*DBIT-1:0] frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   err_timeout,
    output logic                   err_overrun,
    output logic                   err_chksum
);

    localparam int IDX_W = (NBYTES + 1 > 1) ? $clog2(NBYTES + 1) : 1;
`ifdef UART_FRAME_CHKSUM_EN
    localparam int LAST_IDX = NBYTES;
`else
    localparam int LAST_IDX = NBYTES - 1;
`endif

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             tmo_clear;
    logic             tmo_hit;

    // counter only runs while collecting; every accepted byte restarts it
    assign tmo_clear   = (state != ST_COLLECT) | rx_done_tick;
    assign frame_valid = (state == ST_HOLD);

    uart_timeout_cnt #(
        .LIMIT (tmo_limit(TIMEOUT_BITS))
    ) u_tmo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (tmo_clear),
        .tick     (s_tick),
        .terminal (tmo_hit)
    );

`ifdef UART_FRAME_CHKSUM_EN
    logic [DBIT-1:0] chk_byte;
    logic [DBIT-1:0] payload_xor;
    logic            chk_err;

    always_comb begin
        payload_xor = '0;
        for (int k = 0; k < NBYTES; k++) begin
            payload_xor = payload_xor ^ frame_data[k*DBIT +: DBIT];
        end
    end

    assign err_chksum = chk_err;
`else
    assign err_chksum = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            frame_data  <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
            chk_byte    <= '0;
            chk_err     <= 1'b0;
`endif
        end else begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
            chk_err     <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (rx_done_tick && rx_data == SOF) begin
                        state <= ST_COLLECT;
                        idx   <= '0;
                    end
                end

                ST_COLLECT: begin
                    // a byte arriving with the terminal tick keeps the frame alive
                    if (rx_done_tick) begin
                        for (int k = 0; k < NBYTES; k++) begin
                            if (idx == IDX_W'(k)) begin
                                frame_data[k*DBIT +: DBIT] <= rx_data;
                            end
                        end
`ifdef UART_FRAME_CHKSUM_EN
                        if (idx == IDX_W'(NBYTES)) begin
                            chk_byte <= rx_data;
                        end
`endif
                        if (idx == IDX_W'(LAST_IDX)) begin
`ifdef UART_FRAME_CHKSUM_EN
                            state <= ST_CHECK;
`else
                            state <= ST_HOLD;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state       <= ST_IDLE;
                        err_timeout <= 1'b1;
                    end
                end

`ifdef UART_FRAME_CHKSUM_EN
                ST_CHECK: begin
                    if (payload_xor == chk_byte) begin
                        state <= ST_HOLD;
                    end else begin
                        state   <= ST_IDLE;
                        chk_err <= 1'b1;
                    end
                end
`endif

                ST_HOLD: begin
                    // held frame is never overwritten; late bytes are dropped, not hunted for SOF
                    if (rx_done_tick) begin
                        err_overrun <= 1'b1;
                    end
                    if (frame_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed scoreboard bench for uart_rx_frame_ctrl (default build)
module tb_uart_rx_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_tick;
    logic        rx_done_tick;
    logic [7:0]  rx_data;
    logic [23:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        err_timeout;
    logic        err_overrun;
    logic        err_chksum;

    int          vectors     = 0;
    int          miscompares = 0;
    int          n_tmo       = 0;
    int          n_ovr       = 0;
    int          n_chk       = 0;
    logic [23:0] sb[$];

    uart_rx_frame_ctrl #(
        .DBIT         (8),
        .NBYTES       (3),
        .SOF          (8'hA5),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .err_chksum   (err_chksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (err_timeout) n_tmo++;
            if (err_overrun) n_ovr++;
            if (err_chksum)  n_chk++;
            if (frame_valid && frame_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_frame observed=%h expected=none", frame_data);
                end else begin
                    check("frame_data", {8'h00, frame_data}, {8'h00, sb.pop_front()});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            s_tick = 1'b1;
            step();
            s_tick = 1'b0;
            step();
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(8'hA5);
        send_byte(b0);
        send_byte(b1);
        check("valid_before_last", {31'd0, frame_valid}, 32'd0);
        send_byte(b2);
        check("valid_latency", {31'd0, frame_valid}, 32'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        s_tick       = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        frame_ready  = 1'b0;
        step();
        step();
        check("reset_data",  {8'h00, frame_data}, 32'd0);
        check("reset_valid", {31'd0, frame_valid}, 32'd0);
        check("reset_errs",  {29'd0, err_timeout, err_overrun, err_chksum}, 32'd0);
        reset_n = 1'b1;
        step();

        // back-to-back frame, consumer ready: valid for one cycle only
        frame_ready = 1'b1;
        sb.push_back(24'h332211);
        send_frame(8'h11, 8'h22, 8'h33);
        step();
        check("ready_drop", {31'd0, frame_valid}, 32'd0);

        // non-SOF bytes in IDLE ignored
        send_byte(8'h00);
        send_byte(8'h7F);
        check("idle_ignore", {31'd0, frame_valid}, 32'd0);
        sb.push_back(24'h030201);
        send_frame(8'h01, 8'h02, 8'h03);
        step();

        // SOF value inside a frame is payload
        sb.push_back(24'hA5A5A5);
        send_frame(8'hA5, 8'hA5, 8'hA5);
        step();

        // timeout exactly at the 320th tick
        send_byte(8'hA5);
        send_byte(8'h11);
        ticks(319);
        step();
        check("tmo_319", n_tmo, 32'd0);
        ticks(1);
        step();
        step();
        check("tmo_320", n_tmo, 32'd1);
        sb.push_back(24'h665544);
        send_frame(8'h44, 8'h55, 8'h66);
        step();

        // byte coinciding with terminal tick keeps the frame
        send_byte(8'hA5);
        send_byte(8'h11);
        ticks(319);
        s_tick = 1'b1;
        send_byte(8'h22);
        s_tick = 1'b0;
        step();
        sb.push_back(24'h332211);
        send_byte(8'h33);
        check("tick_byte_valid", {31'd0, frame_valid}, 32'd1);
        step();
        step();
        check("tick_byte_no_tmo", n_tmo, 32'd1);

        // overrun while held, ready low
        frame_ready = 1'b0;
        sb.push_back(24'h332211);
        send_frame(8'h11, 8'h22, 8'h33);
        step();
        send_byte(8'h44);
        step();
        step();
        check("ovr_count", n_ovr, 32'd1);
        check("ovr_hold_valid", {31'd0, frame_valid}, 32'd1);
        check("ovr_hold_data", {8'h00, frame_data}, 32'h00332211);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        step();
        check("ovr_release", {31'd0, frame_valid}, 32'd0);

        // overrun with ready in the same cycle; dropped SOF must not start a frame
        sb.push_back(24'h332211);
        send_frame(8'h11, 8'h22, 8'h33);
        step();
        frame_ready = 1'b1;
        send_byte(8'hA5);
        frame_ready = 1'b0;
        step();
        check("ovr_ready_count", n_ovr, 32'd2);
        check("ovr_ready_valid", {31'd0, frame_valid}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        step();
        check("ovr_not_sof", {31'd0, frame_valid}, 32'd0);

        // reset mid-frame: silent abort
        frame_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h11);
        reset_n = 1'b0;
        #1;
        check("rst_mid_data",  {8'h00, frame_data}, 32'd0);
        check("rst_mid_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_mid_errs",  {29'd0, err_timeout, err_overrun, err_chksum}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        sb.push_back(24'hCCBBAA);
        send_frame(8'hAA, 8'hBB, 8'hCC);
        step();
        step();

        check("tmo_total", n_tmo, 32'd1);
        check("ovr_total", n_ovr, 32'd2);
        check("chk_never", n_chk, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
